shift_register_collect: RTL and testbench

//  Receive-side counterpart of shift_register: collects L words of B bits, one per

---
 rtl/shift_register_collect_pkg.sv | 8 +
 rtl/shift_register_collect.sv | 72 +++++++
 tb/tb_shift_register_collect.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_register_collect_pkg.sv
// rtl/shift_register_collect_pkg.sv - shared defaults for the serial collect path
package shift_register_collect_pkg;

  // Word geometry shared with the transmit-side shift_register
  localparam int SR_B_DEFAULT = 8;
  localparam int SR_L_DEFAULT = 4;

endpackage

// File: rtl/shift_register_collect.sv
// rtl/shift_register_collect.sv - collects L serial words of B bits into one double-buffered parallel word
module shift_register_collect
  import shift_register_collect_pkg::*;
#(
  parameter int B = SR_B_DEFAULT,
  parameter int L = SR_L_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [B-1:0]   data_in,
  input  logic           we,
  output logic           ready,
  output logic [B*L-1:0] data_out,
  output logic           full,
  input  logic           re,
  output logic           overrun
);

  localparam int CW = (L > 2) ? $clog2(L) : 1;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  logic [CW-1:0]      count_q;
  logic [(L-1)*B-1:0] shift_q;
  logic [B*L-1:0]     data_out_q;
  logic               full_q;
  logic               overrun_q;

  // Shift stage with the incoming word appended; the low part is the next
  // shift stage, the whole thing is the finished word on completion
  logic [B*L-1:0]     shift_cat_d;
  logic               accept_d;

  assign shift_cat_d = {shift_q, data_in};
  assign accept_d    = we && ready;

  // Only the held-word-plus-last-slot case stalls; derived from state alone
  assign ready = !((count_q == LAST) && full_q);

  // Collection counter, shift stage, holding buffer and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // A read frees the buffer; a completion on the same edge refills it
      if (re && full_q) begin
        full_q <= 1'b0;
      end
      if (accept_d) begin
        if (count_q == LAST) begin
          data_out_q <= shift_cat_d;
          full_q     <= 1'b1;
          count_q    <= '0;
        end else begin
          shift_q <= shift_cat_d[(L-1)*B-1:0];
          count_q <= count_q + 1'b1;
        end
      end
      if (we && !ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign data_out = data_out_q;
  assign full     = full_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_shift_register_collect.sv
// tb/tb_shift_register_collect.sv - directed vector bench for shift_register_collect
module tb_shift_register_collect;

  localparam int B = 8;
  localparam int L = 4;

  logic           clk;
  logic           reset;
  logic [B-1:0]   data_in;
  logic           we;
  logic           ready;
  logic [B*L-1:0] data_out;
  logic           full;
  logic           re;
  logic           overrun;

  int n_cmp;
  int n_bad;

  shift_register_collect #(.B(B), .L(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .we       (we),
    .ready    (ready),
    .data_out (data_out),
    .full     (full),
    .re       (re),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [7:0]  din;
    logic        re;
    logic        rdy;
    logic        full;
    logic [31:0] dout;
    logic        ovr;
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_cycle(input logic r, input logic w, input logic [7:0] d, input logic rd);
    @(negedge clk);
    reset   = r;
    we      = w;
    data_in = d;
    re      = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic erdy, input logic efull,
                           input logic [31:0] edout, input logic eovr);
    check({tag, ".ready"},    {31'd0, ready},   {31'd0, erdy});
    check({tag, ".full"},     {31'd0, full},    {31'd0, efull});
    check({tag, ".data_out"}, data_out,         edout);
    check({tag, ".overrun"},  {31'd0, overrun}, {31'd0, eovr});
  endtask

  initial begin
    logic [31:0] sr;
    logic [31:0] words[2];

    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    we      = 1'b0;
    re      = 1'b0;
    data_in = '0;

    //           rst  we   din    re    rdy   full  dout          ovr
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    // basic collection
    vecs[1]  = '{1'b0, 1'b1, 8'haa, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hbb, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hcc, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hdd, 1'b0, 1'b1, 1'b1, 32'haabbccdd, 1'b0};
    // held word unread: stall after 3 more, 4th dropped
    vecs[5]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 32'haabbccdd, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 32'haabbccdd, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 32'haabbccdd, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 32'haabbccdd, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'haabbccdd, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h01020305, 1'b1};
    // read, then read while empty is ignored
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h01020305, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h01020305, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h01020305, 1'b1};
    // reset clears sticky overrun; re alongside the last word
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 32'h11223344, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h11223344, 1'b0};
    // reset mid-collection discards partial words
    vecs[20] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h11223344, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h11223344, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 8'h0a, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 8'h0b, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 8'h0c, 1'b0, 1'b1, 1'b0, 32'h00000000, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 8'h0d, 1'b0, 1'b1, 1'b1, 32'h0a0b0c0d, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 8'he1, 1'b1, 1'b1, 1'b0, 32'h0a0b0c0d, 1'b0};

    for (int i = 0; i < 28; i++) begin
      drive_cycle(vecs[i].rst, vecs[i].we, vecs[i].din, vecs[i].re);
      check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].full, vecs[i].dout, vecs[i].ovr);
    end

    // loopback: transmit-side model sends MSB word first
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    sr = 32'haabbccdd;
    for (int i = 0; i < L; i++) begin
      drive_cycle(1'b0, 1'b1, sr[31:24], 1'b0);
      sr = sr << 8;
    end
    check_all("loopback", 1'b1, 1'b1, 32'haabbccdd, 1'b0);

    // back-to-back words with a prompt reader: no stall, one word per L cycles
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b0);
    words[0] = 32'hdeadbeef;
    words[1] = 32'h12345678;
    for (int w = 0; w < 2; w++) begin
      sr = words[w];
      for (int i = 0; i < L; i++) begin
        drive_cycle(1'b0, 1'b1, sr[31:24], full);
        sr = sr << 8;
        check($sformatf("stream%0d_%0d.ready", w, i), {31'd0, ready}, 32'd1);
      end
      check_all($sformatf("stream%0d", w), 1'b1, 1'b1, words[w], 1'b0);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check_all("stream_drain", 1'b1, 1'b0, 32'h12345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
